// File: rtl/cnt_job_sched_pkg.sv
// cnt_sched_pkg: shared FSM state type and default parameters for the counter job scheduler
package cnt_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATABIT = 8;
  localparam int DEF_TO_CYC = 1024;
endpackage

// File: rtl/cnt_job_sched_if.sv
// cnt_job_sched_if: client-side job request/response bundle of the counter job scheduler
interface cnt_job_sched_if
  import cnt_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATABIT = DEF_DATABIT
);
  localparam int IDW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] i_req;
  logic [NUM_REQ*DATABIT-1:0] i_req_cnt;
  logic [NUM_REQ-1:0] o_ack;
  logic [NUM_REQ-1:0] o_done;
  logic o_err;
  logic o_busy;
  logic [IDW-1:0] o_grant_id;
  modport master (output i_req, i_req_cnt, input o_ack, o_done, o_err, o_busy, o_grant_id);
  modport slave (input i_req, i_req_cnt, output o_ack, o_done, o_err, o_busy, o_grant_id);
endinterface

// File: rtl/cnt_job_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, priority ptr, ptr+1, ... wrapping
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     id
);
  always_comb begin
    id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NUM_REQ]) id = IDW'((int'(ptr) + i) % NUM_REQ);
    gnt = |req ? NUM_REQ'(1) << id : '0;
  end
endmodule

// File: rtl/cnt_job_sched.sv
// cnt_job_sched: round-robin scheduler sharing one counter core among NUM_REQ requesters
module cnt_job_sched
  import cnt_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATABIT = DEF_DATABIT,
  parameter int TO_CYC = DEF_TO_CYC
) (
  input  logic               clk,
  input  logic               reset_n,
  cnt_job_sched_if.slave     bus,
  output logic [DATABIT-1:0] o_cnt_num,
  output logic               o_cnt_run,
  input  logic               i_cnt_idle,
  input  logic               i_cnt_done
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TO_CYC) + 1;
  state_t state;
  logic [IDW-1:0] ptr, win, nxt;
  logic [NUM_REQ-1:0] gnt;
  logic [WW-1:0] wd;
  logic [DATABIT-1:0] win_cnt;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (.req(bus.i_req), .ptr(ptr), .gnt(gnt), .id(win));
  assign win_cnt = bus.i_req_cnt[win*DATABIT +: DATABIT];
  assign nxt = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  // Timeout fires when the incremented watchdog would hit TO_CYC-1, giving done exactly TO_CYC cycles after launch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      ptr <= '0;
      wd <= '0;
      bus.o_ack <= '0;
      bus.o_done <= '0;
      bus.o_err <= 1'b0;
      bus.o_busy <= 1'b0;
      bus.o_grant_id <= '0;
      o_cnt_num <= '0;
      o_cnt_run <= 1'b0;
    end else begin
      bus.o_ack <= '0;
      bus.o_done <= '0;
      bus.o_err <= 1'b0;
      o_cnt_run <= 1'b0;
      case (state)
        S_IDLE: if (|gnt && i_cnt_idle) begin
          bus.o_grant_id <= win;
          o_cnt_num <= win_cnt;
          ptr <= nxt;
          bus.o_ack <= gnt;
          bus.o_busy <= 1'b1;
          state <= (win_cnt != '0) ? S_LAUNCH : S_DONE;
          o_cnt_run <= (win_cnt != '0);
          bus.o_done <= (win_cnt != '0) ? '0 : gnt;
        end
        S_LAUNCH: begin
          wd <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          wd <= wd + 1'b1;
          if (i_cnt_done || wd == WW'(TO_CYC - 2)) begin
            state <= S_DONE;
            bus.o_done <= NUM_REQ'(1) << bus.o_grant_id;
            bus.o_err <= !i_cnt_done;
          end
        end
        default: begin
          state <= S_IDLE;
          bus.o_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
